// File: rtl/count_evt_cond_if.sv
// Signal bundle between the event conditioner and whatever drives/observes it.
// master = stimulus/upstream side, slave = the conditioner itself.
interface count_evt_cond_if;
    logic evt_in;
    logic enable;
    logic clr_req;
    logic ovf_in;
    logic count_en;
    logic count_clr;
    logic evt_level;
    logic ovf_sticky;
    logic drop_pulse;

    modport master (
        output evt_in, enable, clr_req, ovf_in,
        input  count_en, count_clr, evt_level, ovf_sticky, drop_pulse
    );

    modport slave (
        input  evt_in, enable, clr_req, ovf_in,
        output count_en, count_clr, evt_level, ovf_sticky, drop_pulse
    );
endinterface

// File: rtl/count_evt_cond.sv
// Event-counter front end: synchronizes and debounces a raw event line, turns
// accepted rising edges into count_en pulses and arbitrates them against clears.
module count_evt_cond #(
    parameter int DB_CYCLES   = 4,
    parameter bit STOP_AT_MAX = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    count_evt_cond_if.slave  bus
);
    typedef enum logic [1:0] {LO, CHK_HI, HI, CHK_LO} state_t;

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    state_t     state, state_nx;
    logic [7:0] db_cnt, db_nx;
    logic       sync1, sync2;
    logic       pend_en;
    logic       accept;
    logic       want;
    logic       blocked;

    always_comb begin
        state_nx = state;
        db_nx    = db_cnt;
        accept   = 1'b0;
        case (state)
            LO: begin
                if (sync2) begin
                    state_nx = CHK_HI;
                    db_nx    = 8'd1;
                end
            end
            CHK_HI: begin
                if (!sync2) begin
                    state_nx = LO;
                    db_nx    = 8'd0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx = HI;
                    db_nx    = 8'd0;
                    accept   = 1'b1;
                end else begin
                    db_nx = db_cnt + 8'd1;
                end
            end
            HI: begin
                if (!sync2) begin
                    state_nx = CHK_LO;
                    db_nx    = 8'd1;
                end
            end
            CHK_LO: begin
                if (sync2) begin
                    state_nx = HI;
                    db_nx    = 8'd0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx = LO;
                    db_nx    = 8'd0;
                end else begin
                    db_nx = db_cnt + 8'd1;
                end
            end
            default: begin
                state_nx = LO;
                db_nx    = 8'd0;
            end
        endcase
        // A deferred event bypasses the enable check; only fresh accepts need it.
        want    = pend_en | (accept & bus.enable);
        blocked = STOP_AT_MAX & bus.ovf_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1          <= 1'b0;
            sync2          <= 1'b0;
            state          <= LO;
            db_cnt         <= 8'd0;
            pend_en        <= 1'b0;
            bus.count_en   <= 1'b0;
            bus.count_clr  <= 1'b0;
            bus.evt_level  <= 1'b0;
            bus.ovf_sticky <= 1'b0;
            bus.drop_pulse <= 1'b0;
        end else begin
            sync1          <= bus.evt_in;
            sync2          <= sync1;
            state          <= state_nx;
            db_cnt         <= db_nx;
            bus.evt_level  <= (state_nx == HI) || (state_nx == CHK_LO);
            bus.count_clr  <= bus.clr_req;
            bus.count_en   <= 1'b0;
            bus.drop_pulse <= 1'b0;

            // Clear has priority at the counter, so events are held back while it is requested.
            if (bus.clr_req) begin
                pend_en <= want;
            end else begin
                pend_en <= 1'b0;
                if (want) begin
                    if (blocked) bus.drop_pulse <= 1'b1;
                    else         bus.count_en   <= 1'b1;
                end
            end

            if (bus.clr_req)
                bus.ovf_sticky <= 1'b0;
            else if (want && bus.ovf_in)
                bus.ovf_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_count_evt_cond.sv
// Directed bench for count_evt_cond: a saturating and a wrapping instance share
// the same stimulus so both overflow policies are exercised side by side.
module tb_count_evt_cond;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic evt = 1'b0, en = 1'b0, clr = 1'b0, ovf = 1'b0;

    int total = 0;
    int bad   = 0;
    int n_en_a = 0, n_en_b = 0, n_drop_a = 0, n_drop_b = 0, n_clr_a = 0;

    count_evt_cond_if ifa ();
    count_evt_cond_if ifb ();

    assign ifa.evt_in  = evt;
    assign ifa.enable  = en;
    assign ifa.clr_req = clr;
    assign ifa.ovf_in  = ovf;
    assign ifb.evt_in  = evt;
    assign ifb.enable  = en;
    assign ifb.clr_req = clr;
    assign ifb.ovf_in  = ovf;

    count_evt_cond #(.DB_CYCLES(4), .STOP_AT_MAX(1'b1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    count_evt_cond #(.DB_CYCLES(4), .STOP_AT_MAX(1'b0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_en_a   += int'(ifa.count_en);
        n_en_b   += int'(ifb.count_en);
        n_drop_a += int'(ifa.drop_pulse);
        n_drop_b += int'(ifb.drop_pulse);
        n_clr_a  += int'(ifa.count_clr);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic zero_counts();
        n_en_a = 0; n_en_b = 0; n_drop_a = 0; n_drop_b = 0; n_clr_a = 0;
    endtask

    initial begin
        // reset state
        idle(2);
        chk("rst_count_en",   ifa.count_en,   0);
        chk("rst_count_clr",  ifa.count_clr,  0);
        chk("rst_evt_level",  ifa.evt_level,  0);
        chk("rst_ovf_sticky", ifa.ovf_sticky, 0);
        chk("rst_drop_pulse", ifa.drop_pulse, 0);
        rst = 1'b0;
        en  = 1'b1;
        idle(3);

        // clean edge: pulse in the cycle after edge 5
        zero_counts();
        evt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("clean_en_k%0d", k), ifa.count_en, (k == 5) ? 1 : 0);
            chk($sformatf("clean_lvl_k%0d", k), ifa.evt_level, (k >= 5) ? 1 : 0);
        end
        chk("clean_total_en", n_en_a, 1);
        evt = 1'b0;
        idle(10);
        chk("clean_fall_lvl", ifa.evt_level, 0);
        chk("clean_fall_no_en", n_en_a, 1);

        // bounce: 3 high, 1 low, then stable high
        zero_counts();
        evt = 1'b1; idle(3);
        evt = 1'b0; idle(1);
        evt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("bounce_en_k%0d", k), ifa.count_en, (k == 5) ? 1 : 0);
        end
        chk("bounce_total_en", n_en_a, 1);
        evt = 1'b0; idle(10);

        // isolated 3-cycle glitch
        zero_counts();
        evt = 1'b1; idle(3);
        evt = 1'b0; idle(10);
        chk("glitch_no_en", n_en_a, 0);
        chk("glitch_lvl", ifa.evt_level, 0);

        // saturation (sat instance) and wrap (wrap instance)
        zero_counts();
        ovf = 1'b1;
        repeat (3) begin
            evt = 1'b1; idle(10);
            evt = 1'b0; idle(10);
        end
        chk("sat_en",      n_en_a, 0);
        chk("sat_drop",    n_drop_a, 3);
        chk("sat_sticky",  ifa.ovf_sticky, 1);
        chk("wrap_en",     n_en_b, 3);
        chk("wrap_drop",   n_drop_b, 0);
        chk("wrap_sticky", ifb.ovf_sticky, 1);
        ovf = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_pulse",      ifa.count_clr, 1);
        chk("clr_sticky_a",   ifa.ovf_sticky, 0);
        chk("clr_sticky_b",   ifb.ovf_sticky, 0);
        tick();
        chk("clr_pulse_end",  ifa.count_clr, 0);
        chk("clr_pulse_cnt",  n_clr_a, 1);

        // collision: clear sampled at edges 4 and 5, accept at edge 5
        idle(2);
        zero_counts();
        evt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("coll_en_k%0d", k), ifa.count_en, (k == 6) ? 1 : 0);
            chk($sformatf("coll_clr_k%0d", k), ifa.count_clr, (k == 4 || k == 5) ? 1 : 0);
            clr = (k == 3 || k == 4);
        end
        chk("coll_total_en", n_en_a, 1);
        chk("coll_total_clr", n_clr_a, 2);
        evt = 1'b0; idle(10);

        // async reset while debouncing a rising edge
        ovf = 1'b1;
        evt = 1'b1; idle(10);
        evt = 1'b0; idle(10);
        ovf = 1'b0;
        evt = 1'b1;
        idle(3);
        chk("arst_a_pre_sticky", ifa.ovf_sticky, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_a_sticky_a", ifa.ovf_sticky, 0);
        chk("arst_a_sticky_b", ifb.ovf_sticky, 0);
        chk("arst_a_lvl",      ifa.evt_level, 0);
        rst = 1'b0;
        zero_counts();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("arst_a_en_k%0d", k), ifb.count_en, (k == 5) ? 1 : 0);
        end
        chk("arst_a_total_en", n_en_a, 1);
        evt = 1'b0; idle(10);

        // async reset while an event is pending behind a held clear
        evt = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            clr = (k >= 3);
        end
        chk("arst_b_pre_clr", ifa.count_clr, 1);
        chk("arst_b_pre_lvl", ifa.evt_level, 1);
        chk("arst_b_pre_en",  ifa.count_en, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_b_clr",  ifa.count_clr, 0);
        chk("arst_b_lvl",  ifa.evt_level, 0);
        chk("arst_b_en",   ifa.count_en, 0);
        chk("arst_b_drop", ifa.drop_pulse, 0);
        rst = 1'b0;
        clr = 1'b0;
        zero_counts();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("arst_b_en_k%0d", k), ifa.count_en, (k == 5) ? 1 : 0);
        end
        chk("arst_b_total_en", n_en_a, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/count_evt_cond.md
Name: count_evt_cond

Overview:
- Upstream conditioner for the 8-bit event counter.
- Converts a raw, asynchronous, bouncy event input into clean single-cycle count_en pulses, one per debounced rising edge.
- Converts clear requests into single-cycle count_clr pulses.
- Reads the counter's overflow flag back to enforce the saturate-or-wrap policy and to keep a sticky overflow status.

Parameters:
- DB_CYCLES, 4: consecutive synchronized samples at the new level required to accept an edge; legal range 2..255.
- STOP_AT_MAX, 1: 1 = drop events while ovf_in is high (counter saturates at 8'hFF); 0 = pass events through (counter wraps).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- evt_in  input  1  raw event line, asynchronous to clk, may bounce
- enable  input  1  synchronous; 0 suppresses count_en generation, debounce keeps running
- clr_req  input  1  synchronous clear request, level-sampled each cycle
- ovf_in  input  1  counter overflow flag (count == 8'hFF)
- count_en  output  1  registered 1-cycle increment pulse to the counter
- count_clr  output  1  registered 1-cycle clear pulse to the counter
- evt_level  output  1  debounced event level
- ovf_sticky  output  1  set on overflow event, cleared by count_clr
- drop_pulse  output  1  registered 1-cycle pulse when an accepted edge is discarded

Behaviour:
- Reset (async, rst=1):
  - sync1, sync2, db_cnt, pend_en are cleared; state = LO.
  - Outputs count_en, count_clr, evt_level, ovf_sticky and drop_pulse are all 0.
  - On release, the first active edge behaves as normal operation.
- Synchronizer: evt_in passes through 2 flops (sync1 -> sync2). s = sync2.
- Debounce FSM: states LO, CHK_HI, HI, CHK_LO; db_cnt is 8 bits.
  - LO: if s=1 -> CHK_HI, db_cnt=1.
  - CHK_HI: if s=0 -> LO, db_cnt=0. Else if db_cnt==DB_CYCLES-1 -> HI and raise accept; else db_cnt+1.
  - HI: if s=1... stays HI. If s=0 -> CHK_LO, db_cnt=1.
  - CHK_LO: if s=1 -> HI, db_cnt=0. Else if db_cnt==DB_CYCLES-1 -> LO; else db_cnt+1.
  - evt_level=1 in HI and CHK_LO, 0 otherwise; it is a registered state decode.
- Latency: evt_in first sampled high at edge 0 and held stable -> count_en is high for the cycle following edge DB_CYCLES+1 (edge 5 for DB_CYCLES=4).
- Only accepted rising edges generate events; falling edges never do.
- Event disposition on accept:
  - enable=0 -> discarded silently, no drop_pulse.
  - STOP_AT_MAX=1 and ovf_in=1 -> discarded, drop_pulse=1, ovf_sticky set.
  - STOP_AT_MAX=0 and ovf_in=1 -> count_en issued and ovf_sticky set (counter wraps to 0).
  - Otherwise -> count_en issued.
- Clear path: clr_req=1 sampled -> count_clr=1 the next cycle.
  - count_clr stays high each cycle clr_req is held.
  - ovf_sticky is cleared in the same cycle count_clr is registered.
- Clear/event collision:
  - The counter gives clear priority, so count_en and count_clr are never asserted together.
  - If an event would issue while clr_req is sampled high, count_clr=1, pend_en=1 and count_en=0.
  - The pending event issues as count_en on the first cycle with clr_req=0 (one event only).
  - The pending event is evaluated against ovf_in at issue time (ovf_in=0 right after the clear).
  - enable is not re-checked for the pending event.
- ovf_sticky set and clear in the same cycle: clear wins.
- Reset mid-debounce: FSM returns to LO, pend_en is lost, and no pulse is emitted after reset release until a fresh DB_CYCLES-stable high is seen.

Test Plan:
- Clean edge: DB_CYCLES=4, enable=1, evt_in 0->1 held 10 cycles -> exactly one count_en, high for the cycle after edge 5; evt_level=1 from the same edge.
- Bounce: evt_in high 3 cycles, low 1, high 6 -> no pulse on the first burst; one count_en 5 edges after the final rise; glitch of 3 cycles alone -> no count_en.
- Saturation: STOP_AT_MAX=1, ovf_in=1, 3 clean events -> count_en stays 0, 3 drop_pulse, ovf_sticky=1; then clr_req 1 cycle -> count_clr 1 cycle, ovf_sticky=0.
- Wrap: STOP_AT_MAX=0, ovf_in=1, one event -> count_en=1, ovf_sticky=1, drop_pulse=0.
- Collision: clr_req held 2 cycles covering the accept cycle -> count_clr 2 cycles, count_en 0 in those cycles, exactly one count_en in the cycle after clr_req drops.
- Async reset: rst asserted mid-CHK_HI and while pend_en=1 -> all outputs 0 immediately (no clock edge needed); no count_en after release until a fresh 4-sample-stable high.
